// File: rtl/skin_pkg.sv
// Shared constants and config-port encodings for the skin-tone chroma transform.
package skin_pkg;

   // Default pass band on Y (inclusive at both ends).
   localparam int K_L_DEF        = 125;
   localparam int K_H_DEF        = 188;

   // Re-centre constants; also the reset contents of the mean tables.
   localparam int CB_MEAN_KH_DEF = 108;
   localparam int CR_MEAN_KH_DEF = 154;

   // Fixed-point position of the gain tables (1.0 == 1 << GAIN_FRAC).
   localparam int GAIN_FRAC_DEF  = 8;

   // cfg_ch: which channel's table pair a write targets.
   typedef enum logic {
      CFG_CH_CB = 1'b0,
      CFG_CH_CR = 1'b1
   } cfg_ch_e;

   // cfg_sel: which table of the pair a write targets.
   typedef enum logic {
      CFG_SEL_MEAN = 1'b0,
      CFG_SEL_GAIN = 1'b1
   } cfg_sel_e;

endpackage

// File: rtl/chroma_skin_transform_if.sv
// Pixel stream, backpressure and table-programming signals of the chroma transform.
interface chroma_skin_transform_if #(
   parameter int DATA_W = 8,
   parameter int LUT_AW = 4,
   parameter int GAIN_W = 10
);
   // Table programming
   logic              cfg_we;
   logic              cfg_ch;
   logic              cfg_sel;
   logic [LUT_AW-1:0] cfg_addr;
   logic [GAIN_W-1:0] cfg_data;

   // Input pixel stream
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_y;
   logic [DATA_W-1:0] in_cb;
   logic [DATA_W-1:0] in_cr;

   // Output pixel stream
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_cb;
   logic [DATA_W-1:0] out_cr;
   logic              out_in_band;

   // Upstream/downstream environment side.
   modport master (
      output cfg_we, cfg_ch, cfg_sel, cfg_addr, cfg_data,
      output in_valid, in_y, in_cb, in_cr, out_ready,
      input  in_ready, out_valid, out_cb, out_cr, out_in_band
   );

   // Transform block side.
   modport slave (
      input  cfg_we, cfg_ch, cfg_sel, cfg_addr, cfg_data,
      input  in_valid, in_y, in_cb, in_cr, out_ready,
      output in_ready, out_valid, out_cb, out_cr, out_in_band
   );

endinterface

// File: rtl/chroma_lane.sv
// One chroma channel: programmable mean/gain tables plus the S1-S4 datapath
// (lookup, diff, multiply, shift/re-centre/clamp with pass-through mux).
module chroma_lane
   import skin_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int LUT_AW    = 4,
   parameter int GAIN_W    = 10,
   parameter int GAIN_FRAC = GAIN_FRAC_DEF,
   parameter int MEAN_KH   = CB_MEAN_KH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [LUT_AW-1:0] lut_idx,
   input  logic [DATA_W-1:0] in_c,
   input  logic              band_s3,
   input  logic              mean_we,
   input  logic              gain_we,
   input  logic [LUT_AW-1:0] cfg_addr,
   input  logic [GAIN_W-1:0] cfg_data,
   output logic [DATA_W-1:0] out_c
);

   localparam int TBL_D  = 2 ** LUT_AW;
   localparam int DIFF_W = DATA_W + 1;
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam int SUM_W  = PROD_W + 1;

   localparam logic [GAIN_W-1:0]       GAIN_ONE = GAIN_W'(2 ** GAIN_FRAC);
   localparam logic signed [SUM_W-1:0] KH_EXT   = SUM_W'(MEAN_KH);
   localparam logic signed [SUM_W-1:0] OUT_MAX  = SUM_W'((2 ** DATA_W) - 1);

   logic [DATA_W-1:0] mean_tbl [TBL_D];
   logic [GAIN_W-1:0] gain_tbl [TBL_D];

   logic [DATA_W-1:0]        s1_c, s1_m, s2_c, s3_c;
   logic [GAIN_W-1:0]        s1_g, s2_g;
   logic signed [DIFF_W-1:0] s2_diff;
   logic signed [PROD_W-1:0] s3_prod;

   logic signed [PROD_W-1:0] diff_ext, g_ext, prod, sh;
   logic signed [SUM_W-1:0]  sum;
   logic [DATA_W-1:0]        clamped;

   // Table storage: written every cycle cfg asks, regardless of pipeline stalls.
   // NOTE: these tables are reset (flops, not RAM) because reset must restore
   // the identity transform; an ordinary memory would keep stale contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TBL_D; i++) begin
            mean_tbl[i] <= DATA_W'(MEAN_KH);
            gain_tbl[i] <= GAIN_ONE;
         end
      end else begin
         if (mean_we) mean_tbl[cfg_addr] <= cfg_data[DATA_W-1:0];
         if (gain_we) gain_tbl[cfg_addr] <= cfg_data;
      end
   end

   // S1: capture chroma and the combinational table read; a same-cycle write
   // lands on the clock edge, so this lookup sees the old entry.
   // NOTE: state uses non-blocking assignments so every stage samples the
   // previous stage's pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_c <= '0;
         s1_m <= '0;
         s1_g <= '0;
      end else if (en) begin
         s1_c <= in_c;
         s1_m <= mean_tbl[lut_idx];
         s1_g <= gain_tbl[lut_idx];
      end
   end

   // S2: signed distance from the programmed mean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_c    <= '0;
         s2_g    <= '0;
         s2_diff <= '0;
      end else if (en) begin
         s2_c    <= s1_c;
         s2_g    <= s1_g;
         s2_diff <= $signed({1'b0, s1_c}) - $signed({1'b0, s1_m});
      end
   end

   // Operand extension, multiply, shift, re-centre and clamp.
   // NOTE: every output of this block is assigned on every path (defaults
   // first), so no latch is inferred.
   always_comb begin
      diff_ext = {{(PROD_W - DIFF_W){s2_diff[DIFF_W-1]}}, s2_diff};
      g_ext    = {{(PROD_W - GAIN_W){1'b0}}, s2_g};
      prod     = diff_ext * g_ext;
      sh       = s3_prod >>> GAIN_FRAC;
      sum      = {sh[PROD_W-1], sh} + KH_EXT;
      clamped  = sum[DATA_W-1:0];
      if (sum < 0)            clamped = '0;
      else if (sum > OUT_MAX) clamped = '1;
   end

   // S3: register the full-precision product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_c    <= '0;
         s3_prod <= '0;
      end else if (en) begin
         s3_c    <= s2_c;
         s3_prod <= prod;
      end
   end

   // S4: pass-through for in-band luma, otherwise the clamped transform.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  out_c <= '0;
      else if (en) out_c <= band_s3 ? s3_c : clamped;
   end

endmodule

// File: rtl/chroma_skin_transform.sv
// Two-channel luma-dependent skin-tone chroma transform: 4-stage stallable
// pipeline with a single global enable, valid/in-band chains and config decode.
module chroma_skin_transform
   import skin_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LUT_AW     = 4,
   parameter int GAIN_W     = 10,
   parameter int GAIN_FRAC  = GAIN_FRAC_DEF,
   parameter int K_L        = K_L_DEF,
   parameter int K_H        = K_H_DEF,
   parameter int CB_MEAN_KH = CB_MEAN_KH_DEF,
   parameter int CR_MEAN_KH = CR_MEAN_KH_DEF
) (
   input logic                   clk,
   input logic                   rst_n,
   chroma_skin_transform_if.slave bus
);

   logic              en;
   logic [LUT_AW-1:0] lut_idx;
   logic              in_band;
   logic              s1_v, s2_v, s3_v;
   logic              s1_band, s2_band, s3_band;
   logic              cb_mean_we, cb_gain_we, cr_mean_we, cr_gain_we;

   // The whole pipe moves together; it only freezes while a finished pixel waits.
   assign en           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;

   assign lut_idx = bus.in_y[DATA_W-1 -: LUT_AW];
   assign in_band = (bus.in_y >= DATA_W'(K_L)) && (bus.in_y <= DATA_W'(K_H));

   // Route a table write strobe to exactly one of the four tables.
   always_comb begin
      cb_mean_we = 1'b0;
      cb_gain_we = 1'b0;
      cr_mean_we = 1'b0;
      cr_gain_we = 1'b0;
      if (bus.cfg_we) begin
         if (cfg_ch_e'(bus.cfg_ch) == CFG_CH_CB) begin
            cb_mean_we = (cfg_sel_e'(bus.cfg_sel) == CFG_SEL_MEAN);
            cb_gain_we = (cfg_sel_e'(bus.cfg_sel) == CFG_SEL_GAIN);
         end else begin
            cr_mean_we = (cfg_sel_e'(bus.cfg_sel) == CFG_SEL_MEAN);
            cr_gain_we = (cfg_sel_e'(bus.cfg_sel) == CFG_SEL_GAIN);
         end
      end
   end

   // Valid and in-band chains alongside the lane datapaths; bubbles ride along.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v            <= 1'b0;
         s2_v            <= 1'b0;
         s3_v            <= 1'b0;
         bus.out_valid   <= 1'b0;
         s1_band         <= 1'b0;
         s2_band         <= 1'b0;
         s3_band         <= 1'b0;
         bus.out_in_band <= 1'b0;
      end else if (en) begin
         s1_v            <= bus.in_valid;
         s2_v            <= s1_v;
         s3_v            <= s2_v;
         bus.out_valid   <= s3_v;
         s1_band         <= in_band;
         s2_band         <= s1_band;
         s3_band         <= s2_band;
         bus.out_in_band <= s3_band;
      end
   end

   chroma_lane #(
      .DATA_W   (DATA_W),
      .LUT_AW   (LUT_AW),
      .GAIN_W   (GAIN_W),
      .GAIN_FRAC(GAIN_FRAC),
      .MEAN_KH  (CB_MEAN_KH)
   ) u_lane_cb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .lut_idx (lut_idx),
      .in_c    (bus.in_cb),
      .band_s3 (s3_band),
      .mean_we (cb_mean_we),
      .gain_we (cb_gain_we),
      .cfg_addr(bus.cfg_addr),
      .cfg_data(bus.cfg_data),
      .out_c   (bus.out_cb)
   );

   chroma_lane #(
      .DATA_W   (DATA_W),
      .LUT_AW   (LUT_AW),
      .GAIN_W   (GAIN_W),
      .GAIN_FRAC(GAIN_FRAC),
      .MEAN_KH  (CR_MEAN_KH)
   ) u_lane_cr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .lut_idx (lut_idx),
      .in_c    (bus.in_cr),
      .band_s3 (s3_band),
      .mean_we (cr_mean_we),
      .gain_we (cr_gain_we),
      .cfg_addr(bus.cfg_addr),
      .cfg_data(bus.cfg_data),
      .out_c   (bus.out_cr)
   );

endmodule

// File: doc/chroma_skin_transform.md
# chroma_skin_transform

Parametrised, two-channel skin-tone chroma transform for the YCbCr datapath. It applies the luma-dependent nonlinear transform to Cb and Cr in parallel through a stallable 4-stage pipeline with valid/ready handshakes. Mean and gain tables are run-time programmable per channel. The block sits between the colour-space converter and the skin classifier, and supersedes the single-channel fixed-table transform.

## Interface

- DATA_W, 8: width of Y, Cb, Cr.
- LUT_AW, 4: table address width. Depth is 2**LUT_AW, indexed by Y[DATA_W-1 -: LUT_AW].
- GAIN_W, 10: unsigned gain width. Must satisfy GAIN_W >= DATA_W.
- GAIN_FRAC, 8: fractional bits of gain.
- K_L, 125: lower bound of the pass band (inclusive).
- K_H, 188: upper bound of the pass band (inclusive).
- CB_MEAN_KH, 108: Cb re-centre constant; also the reset value of every Cb mean entry.
- CR_MEAN_KH, 154: Cr re-centre constant; also the reset value of every Cr mean entry.

Ports:

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- cfg_we  in  1  table write strobe.
- cfg_ch  in  1  0=Cb table, 1=Cr table.
- cfg_sel  in  1  0=mean entry, 1=gain entry.
- cfg_addr  in  LUT_AW  entry index.
- cfg_data  in  GAIN_W  write data. A mean entry takes cfg_data[DATA_W-1:0].
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel.
- in_y, in_cb, in_cr  in  DATA_W each  input pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts a pixel.
- out_cb, out_cr  out  DATA_W each  transformed chroma.
- out_in_band  out  1  Y was within [K_L, K_H].

## Operation

- Tables: four register arrays, mean_cb, gain_cb, mean_cr and gain_cr, each 2**LUT_AW deep.
- Reset state of the tables: mean_cb = CB_MEAN_KH, mean_cr = CR_MEAN_KH, every gain = 1<<GAIN_FRAC. This makes the block an identity transform after reset.
- Per channel C, with m = mean[idx(Y)] and g = gain[idx(Y)]:
  - If K_L <= Y <= K_H, out = C (pass-through).
  - Otherwise:
    - diff = C - m, signed, DATA_W+1 bits.
    - prod = diff * g, signed, DATA_W+GAIN_W+1 bits.
    - sh = prod >>> GAIN_FRAC (arithmetic shift; truncation toward -inf).
    - out = clamp(sh + MEAN_KH, 0, 2**DATA_W-1).
- Pipeline stages:
  - S1: register Y/Cb/Cr, in-band flag, and the table reads (combinational read on in_y).
  - S2: diff.
  - S3: multiply.
  - S4: add, clamp and pass-through mux, driving out_* registers directly.
- Handshake:
  - Global enable en = !out_valid || out_ready. All stages advance only when en=1.
  - in_ready = en.
  - A pixel transfers on in_valid && in_ready. Bubbles propagate as valid=0 and are not compressed.
  - out_* and out_valid are held stable while out_valid && !out_ready.
- Config writes:
  - Accepted every cycle, independent of stalls.
  - A write is visible to lookups starting the cycle after cfg_we.
  - A lookup and a write to the same entry in the same cycle: the lookup reads the old value.
  - Pixels already past S1 are unaffected by the write.

## Timing

- Latency: 4 cycles from an accepted input to out_valid, with no stall. Throughput is 1 pixel/cycle.
- Reset, asserted at any time including mid-stream:
  - out_valid=0, out_cb=0, out_cr=0, out_in_band=0.
  - All stage valids are cleared; in-flight pixels are discarded.
  - Tables return to their reset values.
  - in_ready=1 during reset and after release.
- Stall: with out_ready low while out_valid is high, in_ready falls in the same cycle (combinational from out_ready). No pixel is lost or duplicated.
- Boundary values:
  - Y=K_L and Y=K_H are in band.
  - Y=K_L-1 and Y=K_H+1 are transformed.

## Structure

- Shared package `skin_pkg`: K_L/K_H defaults, CB_MEAN_KH/CR_MEAN_KH, the GAIN_FRAC default, and the cfg_ch/cfg_sel encodings.
- Sub-module `chroma_lane`, instanced twice (one per channel). It holds:
  - the mean/gain table pair,
  - the S1–S4 arithmetic,
  - a MEAN_KH parameter.
- The top level holds the handshake enable, valid shift chain, in-band flag chain and config decode.

## Test plan

- Post-reset identity: Y=50, Cb=200, Cr=30, out_ready=1 → 4 cycles later out_cb=200, out_cr=30, out_in_band=0.
- Programmed gain: write mean_cb[3]=100 and gain_cb[3]=512, then input Y=50, Cb=110 → out_cb = (10*512>>8)+108 = 128.
- Clamp, using the same table:
  - Cb=255 → 418 → out_cb=255.
  - Cb=0 → -92 → out_cb=0.
- Pass band, after programming gain_cb[9]=0:
  - Y=150, Cb=77 → out_cb=77, out_in_band=1.
  - Y=124 and Y=189 → transformed.
  - Y=125 and Y=188 → pass-through.
- Backpressure: stream 8 distinct pixels back-to-back with out_ready low for cycles 5–7 → in_ready low in those cycles, outputs held stable, all 8 outputs in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 pixels in flight and modified tables → out_valid drops immediately, and none of the in-flight pixels emerge. After release, Y=50, Cb=110 → out_cb=110 (identity restored).
